// File: rtl/hazard_forwarder.sv
// Load-use stall and registered forwarding-select generator for the 5-stage core.
// Keeps a registered shadow of the EX/MEM/WB decode and computes selects one stage ahead.
module hazard_forwarder #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RS     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] id_inst_i,
    input  logic                  id_valid_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  ex_bubble_o,
    output logic [2*NUM_RS-1:0]   foward_o,
    output logic                  ex_valid_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wren;
        logic       is_load;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t              ex_q, mem_q, wb_q;
    stage_t              id_dec;
    logic [4:0]          op;
    logic [4:0]          rs [NUM_RS];
    logic [NUM_RS-1:0]   rs_used;
    logic                ex_hit;
    logic                load_use;
    logic                advance;
    logic [2*NUM_RS-1:0] fwd_d;

    // Instruction bits outside the decoded fields and the WB shadow have no consumer here.
    logic unused_bits;
    assign unused_bits = ^{id_inst_i, wb_q};

    always_comb begin
        op             = id_inst_i[6:2];
        id_dec.valid   = id_valid_i;
        id_dec.rd      = id_inst_i[11:7];
        id_dec.is_load = (op == 5'b00000);
        id_dec.wren    = id_valid_i && (id_inst_i[11:7] != 5'd0)
                         && (op != 5'b11000) && (op != 5'b01000);
        rs      = '{default: '0};
        rs_used = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (k == 0) begin
                rs[k]      = id_inst_i[19:15];
                rs_used[k] = !(op inside {5'b01101, 5'b00101, 5'b11011});
            end else if (k == 1) begin
                rs[k]      = id_inst_i[24:20];
                rs_used[k] = (op inside {5'b01100, 5'b01000, 5'b11000});
            end else begin
                rs[k]      = id_inst_i[31:27];
                rs_used[k] = (op[4:2] == 3'b100);
            end
        end
    end

    // A load in EX cannot forward to the next consumer; only its MEM-stage successor can.
    always_comb begin
        ex_hit = 1'b0;
        fwd_d  = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (rs_used[k]) begin
                if (ex_q.rd == rs[k]) ex_hit = 1'b1;
                fwd_d[2*k+1] = ex_q.wren && !ex_q.is_load && (ex_q.rd == rs[k]);
                fwd_d[2*k]   = mem_q.wren && (mem_q.rd == rs[k]);
            end
        end
        load_use    = ex_q.valid && ex_q.is_load && ex_q.wren && ex_hit;
        stall_o     = load_use && id_valid_i && !flush_i;
        ex_bubble_o = stall_o || flush_i;
        advance     = id_valid_i && !stall_o && !flush_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q       <= BUBBLE;
            mem_q      <= BUBBLE;
            wb_q       <= BUBBLE;
            foward_o   <= '0;
            ex_valid_o <= 1'b0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (advance) begin
                ex_q       <= id_dec;
                foward_o   <= fwd_d;
                ex_valid_o <= 1'b1;
            end else begin
                ex_q       <= BUBBLE;
                foward_o   <= '0;
                ex_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forwarder.sv
// Bench for hazard_forwarder: directed hazard scenarios with literal expectations,
// then randomized instruction streams checked every cycle against a pipeline-level model.
module tb_hazard_forwarder;

    localparam int DW  = 32;
    localparam int NRS = 3;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_FMADD  = 5'b10000;
    localparam logic [4:0] OP_FNMADD = 5'b10011;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    logic            clk_i      = 1'b0;
    logic            rst_ni     = 1'b0;
    logic [DW-1:0]   id_inst_i  = '0;
    logic            id_valid_i = 1'b0;
    logic            flush_i    = 1'b0;
    logic            stall_o;
    logic            ex_bubble_o;
    logic [2*NRS-1:0] foward_o;
    logic            ex_valid_o;

    int n_vec = 0;
    int n_bad = 0;

    // Model: raw instruction words held in EX, MEM, WB (index 0..2) plus registered outputs.
    logic             m_v [3];
    logic [31:0]      m_i [3];
    logic [2*NRS-1:0] m_fwd;
    logic             m_exv;
    logic             exp_stall;
    logic             last_stall;
    logic             last_bubble;

    hazard_forwarder #(.DATA_WIDTH(DW), .NUM_RS(NRS)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .id_inst_i   (id_inst_i),
        .id_valid_i  (id_valid_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .ex_bubble_o (ex_bubble_o),
        .foward_o    (foward_o),
        .ex_valid_o  (ex_valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [4:0] r3);
        return {r3, 2'b00, r2, r1, 3'b010, rd, op, 2'b11};
    endfunction

    function automatic logic is_ld(input logic [31:0] i);
        return i[6:2] == OP_LOAD;
    endfunction

    function automatic logic writes(input logic [31:0] i);
        return (i[11:7] != 5'd0) && (i[6:2] != OP_BRANCH) && (i[6:2] != OP_STORE);
    endfunction

    function automatic logic uses(input logic [31:0] i, input int k);
        logic [4:0] op;
        op = i[6:2];
        case (k)
            0:       return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
            1:       return op == OP_OP || op == OP_STORE || op == OP_BRANCH;
            default: return op >= 5'b10000 && op <= 5'b10011;
        endcase
    endfunction

    function automatic logic [4:0] src(input logic [31:0] i, input int k);
        case (k)
            0:       return i[19:15];
            1:       return i[24:20];
            default: return i[31:27];
        endcase
    endfunction

    function automatic logic reads(input logic [31:0] i, input logic [4:0] r);
        for (int k = 0; k < NRS; k++)
            if (uses(i, k) && src(i, k) == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2*NRS-1:0] fwd_of(input logic [31:0] i);
        logic [2*NRS-1:0] f;
        f = '0;
        for (int k = 0; k < NRS; k++) begin
            if (uses(i, k)) begin
                f[2*k+1] = m_v[0] && writes(m_i[0]) && !is_ld(m_i[0]) && m_i[0][11:7] == src(i, k);
                f[2*k]   = m_v[1] && writes(m_i[1]) && m_i[1][11:7] == src(i, k);
            end
        end
        return f;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [4:0] op;
        case ($urandom_range(0, 10))
            0: op = OP_LOAD;   1: op = OP_OPIMM;  2: op = OP_AUIPC;  3: op = OP_STORE;
            4: op = OP_OP;     5: op = OP_LUI;    6: op = OP_FMADD;  7: op = OP_FNMADD;
            8: op = OP_BRANCH; 9: op = OP_JALR;   default: op = OP_JAL;
        endcase
        return mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            m_v[s] = 1'b0;
            m_i[s] = '0;
        end
        m_fwd = '0;
        m_exv = 1'b0;
    endtask

    task automatic compare(input logic exp_bubble);
        check("stall_o", 32'(stall_o), 32'(exp_stall));
        check("ex_bubble_o", 32'(ex_bubble_o), 32'(exp_bubble));
        check("foward_o", 32'(foward_o), 32'(m_fwd));
        check("ex_valid_o", 32'(ex_valid_o), 32'(m_exv));
    endtask

    task automatic step(input logic [31:0] inst, input logic v, input logic fl, input logic rst);
        logic [2*NRS-1:0] nf;
        logic adv;
        @(negedge clk_i);
        rst_ni     = rst;
        id_inst_i  = inst;
        id_valid_i = v;
        flush_i    = fl;
        #1;
        if (!rst) model_clear();
        exp_stall = rst && m_v[0] && is_ld(m_i[0]) && writes(m_i[0]) && v && !fl
                    && reads(inst, m_i[0][11:7]);
        compare(rst && (exp_stall || fl));
        last_stall  = stall_o;
        last_bubble = ex_bubble_o;
        adv = rst && v && !exp_stall && !fl;
        nf  = fwd_of(inst);
        @(posedge clk_i);
        if (rst) begin
            m_v[2] = m_v[1]; m_i[2] = m_i[1];
            m_v[1] = m_v[0]; m_i[1] = m_i[0];
            m_v[0] = adv;    m_i[0] = inst;
            m_fwd  = adv ? nf : '0;
            m_exv  = adv;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step('0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] cur, add_rd7;
        logic        v, fl, r;
        model_clear();

        // Reset then idle.
        for (int c = 0; c < 3; c++) begin
            step('0, 1'b0, 1'b0, 1'b0);
            check("rst_stall", 32'(stall_o), 32'd0);
            check("rst_fwd", 32'(foward_o), 32'd0);
            check("rst_exv", 32'(ex_valid_o), 32'd0);
        end
        idle(2);
        check("idle_fwd", 32'(foward_o), 32'd0);
        check("idle_exv", 32'(ex_valid_o), 32'd0);

        // ALU chain, back to back and with one gap.
        step(mk(OP_OP, 5, 1, 2, 0), 1'b1, 1'b0, 1'b1);
        step(mk(OP_OP, 6, 5, 5, 0), 1'b1, 1'b0, 1'b1);
        check("alu_b2b", 32'(foward_o), 32'b001010);
        check("alu_b2b_exv", 32'(ex_valid_o), 32'd1);
        idle(3);
        step(mk(OP_OP, 5, 1, 2, 0), 1'b1, 1'b0, 1'b1);
        idle(1);
        step(mk(OP_OP, 6, 5, 5, 0), 1'b1, 1'b0, 1'b1);
        check("alu_gap", 32'(foward_o), 32'b000101);
        idle(3);

        // Load-use: one stall cycle, then WB select on rs1.
        step(mk(OP_LOAD, 7, 1, 0, 0), 1'b1, 1'b0, 1'b1);
        step(mk(OP_OP, 8, 7, 3, 0), 1'b1, 1'b0, 1'b1);
        check("lu_stall", 32'(last_stall), 32'd1);
        check("lu_bubble", 32'(last_bubble), 32'd1);
        check("lu_exv_bubble", 32'(ex_valid_o), 32'd0);
        step(mk(OP_OP, 8, 7, 3, 0), 1'b1, 1'b0, 1'b1);
        check("lu_release", 32'(last_stall), 32'd0);
        check("lu_fwd", 32'(foward_o), 32'b000001);
        idle(3);

        // lui after a load: rs1 unused, no stall.
        step(mk(OP_LOAD, 7, 1, 0, 0), 1'b1, 1'b0, 1'b1);
        step(mk(OP_LUI, 7, 7, 7, 0), 1'b1, 1'b0, 1'b1);
        check("lui_nostall", 32'(last_stall), 32'd0);
        idle(3);

        // Store whose imm field looks like rd=x9, then a reader of x9.
        step(mk(OP_STORE, 9, 2, 9, 0), 1'b1, 1'b0, 1'b1);
        step(mk(OP_OP, 10, 9, 9, 0), 1'b1, 1'b0, 1'b1);
        check("store_nofwd", 32'(foward_o), 32'd0);
        idle(3);

        // Writes to x0 never forward.
        step(mk(OP_OP, 0, 1, 2, 0), 1'b1, 1'b0, 1'b1);
        step(mk(OP_OP, 3, 0, 0, 0), 1'b1, 1'b0, 1'b1);
        check("x0_nofwd", 32'(foward_o), 32'd0);
        idle(3);

        // Double hit: producers in both MEM and WB positions.
        step(mk(OP_OP, 5, 1, 2, 0), 1'b1, 1'b0, 1'b1);
        step(mk(OP_OPIMM, 5, 5, 0, 0), 1'b1, 1'b0, 1'b1);
        step(mk(OP_OP, 6, 5, 0, 0), 1'b1, 1'b0, 1'b1);
        check("double_hit", 32'(foward_o), 32'b000011);
        idle(3);

        // Flush during a would-be stall.
        step(mk(OP_LOAD, 7, 1, 0, 0), 1'b1, 1'b0, 1'b1);
        step(mk(OP_OP, 8, 7, 7, 0), 1'b1, 1'b1, 1'b1);
        check("flush_stall", 32'(last_stall), 32'd0);
        check("flush_bubble", 32'(last_bubble), 32'd1);
        check("flush_exv", 32'(ex_valid_o), 32'd0);
        check("flush_fwd", 32'(foward_o), 32'd0);
        idle(3);

        // rs3 load-use on fmadd.
        step(mk(OP_LOAD, 4, 1, 0, 0), 1'b1, 1'b0, 1'b1);
        step(mk(OP_FMADD, 1, 2, 3, 4), 1'b1, 1'b0, 1'b1);
        check("rs3_stall", 32'(last_stall), 32'd1);
        step(mk(OP_FMADD, 1, 2, 3, 4), 1'b1, 1'b0, 1'b1);
        check("rs3_release", 32'(last_stall), 32'd0);
        check("rs3_fwd", 32'(foward_o), 32'b010000);
        idle(3);

        // Reset asserted mid-stall drops the stall at once.
        step(mk(OP_LOAD, 7, 1, 0, 0), 1'b1, 1'b0, 1'b1);
        add_rd7 = mk(OP_OP, 8, 7, 7, 0);
        @(negedge clk_i);
        id_inst_i  = add_rd7;
        id_valid_i = 1'b1;
        #1;
        check("pre_rst_stall", 32'(stall_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall_o), 32'd0);
        check("mid_rst_bubble", 32'(ex_bubble_o), 32'd0);
        check("mid_rst_exv", 32'(ex_valid_o), 32'd0);
        model_clear();
        step(add_rd7, 1'b1, 1'b0, 1'b0);
        step(add_rd7, 1'b1, 1'b0, 1'b1);
        check("restart_nostall", 32'(last_stall), 32'd0);
        idle(3);

        // Randomized streams; a stalled instruction is held in ID as the core would.
        cur = rnd_inst();
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 11) == 0);
            r  = ($urandom_range(0, 149) != 0);
            if (!r) fl = 1'b0;
            step(cur, v, fl, r);
            if (!exp_stall) cur = rnd_inst();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_forwarder.md
Name: hazard_forwarder

Overview:
- Next-generation hazard/forwarding block for the 5-stage pipelined core, replacing the purely combinational forwarder.
- Keeps its own registered shadow of the EX/MEM/WB instruction decode (valid, rd, write-enable, is-load).
- Each cycle it produces forwarding selects for the instruction entering EX, a load-use stall, and a bubble for EX.
- Generalised to NUM_RS source operands and opcode-aware source usage, so U/J-type instructions never cause false hazards.

Parameters:
- DATA_WIDTH, 32: instruction width; RISC-V field positions are fixed within it.
- NUM_RS, 2: source operands tracked, 1..3. Operand 0 = rs1 [19:15], operand 1 = rs2 [24:20], operand 2 = rs3 [31:27].

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- id_inst_i  in  DATA_WIDTH  instruction currently in ID
- id_valid_i  in  1  id_inst_i holds a real instruction
- flush_i  in  1  taken branch/jump resolved; kill the ID instruction
- stall_o  out  1  hold PC, IF/ID registers (combinational)
- ex_bubble_o  out  1  load a NOP into ID/EX next edge (combinational)
- foward_o  out  2*NUM_RS  registered selects for the EX instruction; bits [2k+1:2k] belong to operand k
- ex_valid_o  out  1  registered; EX holds a real instruction

Behaviour:
- Decode, using op = inst[6:2]:
  - is_load = (op == 00000).
  - wren = valid && rd != 0 && op not in {11000, 01000}.
  - rs1 is used unless op in {01101, 00101, 11011}.
  - rs2 is used only when op in {01100, 01000, 11000}.
  - rs3 is used only when op in {10000, 10001, 10010, 10011}.
  - An unused operand never matches anything.
- Shadow registers ex_q, mem_q, wb_q each hold {valid, rd, wren, is_load}.
- Every edge: wb_q <= mem_q and mem_q <= ex_q.
- ex_q <= decode(id_inst_i) only when id_valid_i=1, stall_o=0 and flush_i=0; otherwise ex_q <= bubble (valid=0).
- load_use = ex_q.valid && ex_q.is_load && ex_q.wren && (ex_q.rd equals any used ID source).
- stall_o = ex_bubble_o = load_use && id_valid_i && !flush_i. flush_i overrides stall: when flush_i=1, stall_o=0 and ex_bubble_o=flush_i.
- Forwarding is registered one stage ahead. When the ID instruction advances, for each used operand k:
  - Bit 2k+1 = ex_q.wren && !ex_q.is_load && ex_q.rd == rs_k (producer will be in MEM).
  - Bit 2k = mem_q.wren && mem_q.rd == rs_k (producer will be in WB; load data is valid here).
  - 2'b11 is legal; the consumer mux gives MEM priority.
- When a bubble enters EX, foward_o <= 0 and ex_valid_o <= 0.
- A single load-use stall resolves in one cycle: the load moves to MEM, the consumer re-evaluates, and the WB bit is set the next edge.
- No WB->ID bypass is handled here; the register file is write-first.
- Reset (asynchronous, rst_ni=0): all shadow valid bits 0, foward_o=0, ex_valid_o=0. This implies stall_o=0 and ex_bubble_o=0 while reset is held.
- Reset mid-stall: the stall drops immediately; the pipeline restarts empty.
- Back-to-back loads to the same rd: only the youngest (in EX) is considered for stall; MEM forwarding always prefers the youngest.
- rd=x0 never forwards and never stalls.

Test Plan:
- Reset then idle: rst_ni low 3 cycles, id_valid_i=0 -> foward_o=0, stall_o=0, ex_valid_o=0 throughout and after release.
- ALU chain: add x5,x1,x2 then sub x6,x5,x5 in consecutive cycles -> when sub is in EX, foward_o[1:0]=2'b10 and [3:2]=2'b10. One instruction gap -> 2'b01 on both.
- Load-use: lw x7,0(x1) then add x8,x7,x3 -> stall_o=ex_bubble_o=1 for exactly one cycle. Then when add is in EX, foward_o[1:0]=2'b01 and [3:2]=2'b00.
- False-hazard suppression:
  - lw x7 then lui x7,0x12345 -> no stall (rs1 unused).
  - sw x9,0(x2) followed by add using x9-slot bits -> no forward from the store (wren=0).
  - add x0,... followed by a reader of x0 -> foward_o=0.
- Double hit: add x5 in WB position and addi x5 in MEM position when a reader of x5 enters EX -> operand select 2'b11.
- Flush during stall: lw x7 / add x7 in ID with flush_i=1 -> stall_o=0, ex_bubble_o=1. Next cycle ex_valid_o=0 and foward_o=0.
- With NUM_RS=3: fmadd reading rs3=x4 after lw x4 -> one stall cycle, then foward_o[5:4]=2'b01.
